// File: rtl/jtag_tap_sequencer.sv
// rtl/jtag_tap_sequencer.sv - JTAG host sequencer: TAP reset, IR/DR scan and idle clocking with TDO capture
// The shadow TAP state follows (tap_state, tms) every edge, so it tracks a real TAP driven by tms.
module jtag_tap_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state
);
    localparam int CNT_W = $clog2(MAX_LEN + 7);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_IDLE = 2'd3;

    localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
                           SHDR = 4'h2, EX1DR = 4'h1, PDR = 4'h3, EX2DR = 4'h0,
                           UPDR = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA,
                           EX1IR = 4'h9, PIR = 4'hB, EX2IR = 4'h8, UPIR = 4'hD;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_RESP} fsm_t;

    fsm_t             state, state_n;
    logic [1:0]       op_q;
    logic [LEN_W-1:0] len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [CNT_W-1:0] step, step_n, len_c, hdr, total;
    logic [IDX_W-1:0] sidx, cidx;
    logic             tms_n, tdi_n, in_shift, last_step, accept, bad_len, shifting;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:     tap_next = m ? TLR   : RTI;
            RTI:     tap_next = m ? SELDR : RTI;
            SELDR:   tap_next = m ? SELIR : CAPDR;
            CAPDR:   tap_next = m ? EX1DR : SHDR;
            SHDR:    tap_next = m ? EX1DR : SHDR;
            EX1DR:   tap_next = m ? UPDR  : PDR;
            PDR:     tap_next = m ? EX2DR : PDR;
            EX2DR:   tap_next = m ? UPDR  : SHDR;
            UPDR:    tap_next = m ? SELDR : RTI;
            SELIR:   tap_next = m ? TLR   : CAPIR;
            CAPIR:   tap_next = m ? EX1IR : SHIR;
            SHIR:    tap_next = m ? EX1IR : SHIR;
            EX1IR:   tap_next = m ? UPIR  : PIR;
            PIR:     tap_next = m ? EX2IR : PIR;
            EX2IR:   tap_next = m ? UPIR  : SHIR;
            UPIR:    tap_next = m ? SELDR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = cmd_ready && cmd_valid;
    assign bad_len   = (cmd_op != OP_RESET) &&
                       ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN)));
    assign last_step = (step == total - CNT_W'(1));
    assign shifting  = (tap_state == SHDR) || (tap_state == SHIR);

    // step indexes the sequence bit currently on tms/tdi; this computes the bit for step+1.
    always_comb begin
        len_c = CNT_W'(len_q);
        hdr   = (op_q == OP_IR) ? CNT_W'(4) : CNT_W'(3);
        case (op_q)
            OP_RESET: total = CNT_W'(6);
            OP_IDLE:  total = len_c;
            default:  total = len_c + hdr + CNT_W'(2);
        endcase
        step_n   = step + CNT_W'(1);
        sidx     = IDX_W'(step_n - hdr);
        cidx     = IDX_W'(step - hdr);
        in_shift = (step_n >= hdr) && (step_n < hdr + len_c);
        tms_n    = 1'b0;
        tdi_n    = 1'b0;
        case (op_q)
            OP_RESET: tms_n = (step_n < CNT_W'(5));
            OP_IDLE:  tms_n = 1'b0;
            default: begin
                if (step_n < hdr) begin
                    tms_n = (op_q == OP_IR) && (step_n == CNT_W'(1));
                end else if (in_shift) begin
                    tms_n = (step_n == hdr + len_c - CNT_W'(1));
                    tdi_n = data_q[sidx];
                end else begin
                    tms_n = (step_n == hdr + len_c);
                end
            end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_INIT:  if (last_step) state_n = S_IDLE;
            S_IDLE:  if (accept) state_n = bad_len ? S_RESP : S_RUN;
            S_RUN:   if (last_step) state_n = S_RESP;
            S_RESP:  if (rsp_ready) state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= S_INIT;
        else         state <= state_n;
    end

    // INIT reuses the RESET-op sequence: op_q resets to OP_RESET and step 0 already drives tms=1.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            tms       <= 1'b1;
            tdi       <= 1'b0;
            tap_state <= TLR;
            step      <= '0;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            tap_state <= tap_next(tap_state, tms);
            case (state)
                S_INIT, S_RUN: begin
                    if (state == S_RUN && shifting) rsp_data[cidx] <= tdo;
                    if (last_step) begin
                        tms <= 1'b0;
                        tdi <= 1'b0;
                    end else begin
                        step <= step_n;
                        tms  <= tms_n;
                        tdi  <= tdi_n;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= cmd_op;
                        len_q    <= cmd_len;
                        data_q   <= cmd_data;
                        step     <= '0;
                        rsp_data <= '0;
                        rsp_err  <= bad_len;
                        tms      <= !bad_len && (cmd_op != OP_IDLE);
                        tdi      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb/tb_jtag_tap_sequencer.sv - self-checking bench for jtag_tap_sequencer with a reference TAP model
module tb_jtag_tap_sequencer;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic               CLK;
    logic               RESETN;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               tms;
    logic               tdi;
    logic               tdo;
    logic [3:0]         tap_state;
    logic               tdo_lb;
    logic               tdo_val;
    logic [3:0]         model_state;

    int n_pass  = 0;
    int n_total = 0;

    jtag_tap_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tms(tms), .tdi(tdi), .tdo(tdo), .tap_state(tap_state)
    );

    assign tdo = tdo_lb ? tdi : tdo_val;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Next-state nibbles indexed by state, one table per tms value.
    function automatic logic [3:0] model_next(input logic [3:0] s, input logic m);
        logic [63:0] t;
        t = m ? 64'hF977_89DD_417F_0155 : 64'hCACC_BABA_62CE_3232;
        return t[{s, 2'b00} +: 4];
    endfunction

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) model_state <= 4'hF;
        else         model_state <= model_next(model_state, tms);
    end

    always @(negedge CLK) check("tap_model", tap_state, model_state);

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic        lb;
        logic        tdo_v;
        int          hold;
        int          cycles;
        logic [63:0] tms_pat;
        logic [31:0] rsp;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check("ready_timeout", cmd_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          n;
        logic [63:0] pat;
        tdo_lb  = v.lb;
        tdo_val = v.tdo_v;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_len   = v.len;
        cmd_data  = v.data;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd2;
        cmd_len   = 6'h3F;
        cmd_data  = ~v.data;
        n   = 0;
        pat = '0;
        @(negedge CLK);
        while (!rsp_valid && n < 60) begin
            pat[n] = tms;
            n++;
            @(negedge CLK);
        end
        check($sformatf("v%0d_rsp_valid", id), rsp_valid, 1);
        check($sformatf("v%0d_cycles", id), n, v.cycles);
        check($sformatf("v%0d_tms_seq", id), pat, v.tms_pat);
        check($sformatf("v%0d_rsp_data", id), rsp_data, v.rsp);
        check($sformatf("v%0d_rsp_err", id), rsp_err, v.err);
        check($sformatf("v%0d_end_state", id), tap_state, 4'hC);
        check($sformatf("v%0d_busy", id), cmd_ready, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge CLK);
            check($sformatf("v%0d_hold_valid", id), rsp_valid, 1);
            check($sformatf("v%0d_hold_data", id), rsp_data, v.rsp);
            check($sformatf("v%0d_hold_ready", id), cmd_ready, 0);
            check($sformatf("v%0d_hold_tms", id), tms, 0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        @(negedge CLK);
        check($sformatf("v%0d_ready_after", id), cmd_ready, 1);
        check($sformatf("v%0d_valid_after", id), rsp_valid, 0);
    endtask

    task automatic check_init();
        logic [5:0] init_tms;
        init_tms = 6'b011111;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("init_tms%0d", k), tms, init_tms[k]);
            check($sformatf("init_state%0d", k), tap_state, 4'hF);
            check($sformatf("init_ready%0d", k), cmd_ready, 0);
            @(negedge CLK);
        end
        check("init_done_ready", cmd_ready, 1);
        check("init_done_state", tap_state, 4'hC);
        check("init_done_tms", tms, 0);
        check("init_no_rsp", rsp_valid, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tms"}, tms, 1);
        check({tag, "_tdi"}, tdi, 0);
        check({tag, "_state"}, tap_state, 4'hF);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        //            op    len   data           lb   tdo  hold cyc  tms pattern          rsp            err
        vecs[0]  = '{2'd2, 6'd8,  32'h000000A5, 1'b1, 1'b0, 0, 13, 64'h0C01,          32'h000000A5, 1'b0};
        vecs[1]  = '{2'd1, 6'd4,  32'h0000000E, 1'b0, 1'b1, 5, 10, 64'h0183,          32'h0000000F, 1'b0};
        vecs[2]  = '{2'd2, 6'd32, 32'hDEADBEEF, 1'b1, 1'b0, 0, 37, 64'hC_0000_0001,   32'hDEADBEEF, 1'b0};
        vecs[3]  = '{2'd2, 6'd0,  32'h12345678, 1'b1, 1'b0, 2, 0,  64'h0,             32'h0,        1'b1};
        vecs[4]  = '{2'd3, 6'd3,  32'hFFFFFFFF, 1'b1, 1'b0, 0, 3,  64'h0,             32'h0,        1'b0};
        vecs[5]  = '{2'd0, 6'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 0, 6,  64'h001F,          32'h0,        1'b0};
        vecs[6]  = '{2'd2, 6'd1,  32'h00000001, 1'b1, 1'b0, 0, 6,  64'h0019,          32'h00000001, 1'b0};
        vecs[7]  = '{2'd1, 6'd33, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0,  64'h0,             32'h0,        1'b1};
        vecs[8]  = '{2'd3, 6'd0,  32'h0,        1'b1, 1'b0, 0, 0,  64'h0,             32'h0,        1'b1};
        vecs[9]  = '{2'd1, 6'd5,  32'h00000013, 1'b0, 1'b0, 0, 11, 64'h0303,          32'h0,        1'b0};
        vecs[10] = '{2'd2, 6'd5,  32'hFFFFFFF6, 1'b1, 1'b0, 0, 10, 64'h0181,          32'h00000016, 1'b0};

        RESETN    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        tdo_lb    = 1'b1;
        tdo_val   = 1'b0;

        @(negedge CLK);
        check_reset_vals("por");
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        check_init();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset while DR shift bit 5 is on the wire.
        tdo_lb = 1'b1;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 6'd8;
        cmd_data  = 32'h0000005A;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        repeat (9) @(negedge CLK);
        check("mid_state", tap_state, 4'h2);
        check("mid_tdi", tdi, 0);
        check("mid_tms", tms, 0);
        RESETN = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) begin
            @(negedge CLK);
            check("mid_rst_no_rsp", rsp_valid, 0);
        end
        RESETN = 1'b1;
        check_init();
        run_vec(vecs[0], 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
